// File: rtl/float_pkg.sv
// Shared float types and constants for the pipelined multiplier.
// Widths are passed in explicitly so one package serves every format.
package float_pkg;

    localparam int EXP_W_DEF  = 5;
    localparam int FRAC_W_DEF = 10;

    typedef logic [63:0] word64_t;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fclass_t;

    // Special-case summary of an operand pair, carried down the pipe with the beat
    typedef struct packed {
        logic sign;
        logic nan;
        logic inf;
        logic zero;
    } special_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic word64_t inf_word(input int exp_w, input int frac_w);
        word64_t one;
        one = 64'd1;
        return ((one << exp_w) - one) << frac_w;
    endfunction

    function automatic word64_t qnan_word(input int exp_w, input int frac_w);
        word64_t one;
        one = 64'd1;
        return inf_word(exp_w, frac_w) | (one << (frac_w - 1));
    endfunction

    function automatic fclass_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_nz);
        if (exp_zero) return frac_nz ? SUB : ZERO;
        if (exp_ones) return frac_nz ? NAN : INF;
        return NORM;
    endfunction

endpackage

// File: rtl/float_multiplier_pipe_if.sv
// Operand/result stream of the float multiplier.
// slave is the multiplier side, master is the producer/consumer side.
interface float_multiplier_pipe_if
    import float_pkg::*;
#(
    parameter int W = 1 + EXP_W_DEF + FRAC_W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         of;
    logic         uf;
    logic         inv;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, of, uf, inv
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, of, uf, inv
    );
endinterface

// File: rtl/float_multiplier_pipe_lzc.sv
// Leading-zero counter; cnt = WIDTH when d is all zero.
// Latency: combinational.
// Backpressure: none, pure function of d.
module leading_zero_counter #(
    parameter  int WIDTH = 22,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d,
    output logic [CNT_W-1:0] cnt
);

    // Ascending scan: the last hit is the most significant set bit
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/float_multiplier_pipe.sv
// Pipelined binary float multiplier: RNE rounding, flush-to-zero output, of/uf/inv flags.
// Latency: 3 cycles (unpack/multiply, normalise, round/pack), one beat per cycle.
// Backpressure: global stall, every stage holds while out_valid && !out_ready.
module float_multiplier_pipe
    import float_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    float_multiplier_pipe_if.slave bus
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int ES_W   = EXP_W + 2;
    localparam int LZ_W   = $clog2(PROD_W + 1);
    localparam int E_W    = ES_W + LZ_W + 1;
    localparam int BIAS   = bias(EXP_W);

    localparam word64_t         INF_FULL  = inf_word(EXP_W, FRAC_W);
    localparam word64_t         QNAN_FULL = qnan_word(EXP_W, FRAC_W);
    localparam logic [W-2:0]    INF_MAG   = INF_FULL[W-2:0];
    localparam logic [W-1:0]    QNAN      = QNAN_FULL[W-1:0];
    localparam logic signed [E_W-1:0] E_TOP = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ONE = E_W'(1);

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- S1: unpack, classify, multiply ----------------
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
    logic [FRAC_W-1:0] fa, fb;
    fclass_t           cls_a, cls_b;
    logic [SIG_W-1:0]  sig_a, sig_b;
    special_t          sp_n;
    logic [PROD_W-1:0] prod_n;
    logic signed [ES_W-1:0] esum_n;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    assign cls_a = classify(ea == '0, &ea, fa != '0);
    assign cls_b = classify(eb == '0, &eb, fb != '0);

    assign sig_a  = {ea != '0, fa};
    assign sig_b  = {eb != '0, fb};
    assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;

    assign sp_n.sign = sa ^ sb;
    assign sp_n.nan  = (cls_a == NAN) || (cls_b == NAN) ||
                       (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF);
    assign sp_n.inf  = (cls_a == INF) || (cls_b == INF);
    assign sp_n.zero = (cls_a == ZERO) || (cls_b == ZERO);

    assign prod_n = PROD_W'(sig_a) * PROD_W'(sig_b);
    assign esum_n = ES_W'(ea_eff) + ES_W'(eb_eff) - ES_W'(BIAS);

    logic              s1_vld;
    special_t          s1_sp;
    logic [PROD_W-1:0] s1_prod;
    logic signed [ES_W-1:0] s1_esum;

    // ---------------- S2: normalise ----------------
    logic [LZ_W-1:0]   lz;
    logic [LZ_W:0]     shamt;
    logic [PROD_W-1:0] norm;
    logic signed [E_W-1:0] e2_n;

    leading_zero_counter #(.WIDTH(PROD_W)) u_lzc (
        .d   (s1_prod),
        .cnt (lz)
    );

    // Shift one past the leading one so it falls off; what remains is frac|guard|sticky
    assign shamt = {1'b0, lz} + (LZ_W + 1)'(1);
    assign norm  = s1_prod << shamt;
    assign e2_n  = E_W'(s1_esum) + E_W'(1) - E_W'(lz);

    logic              s2_vld;
    special_t          s2_sp;
    logic [FRAC_W-1:0] s2_frac;
    logic              s2_guard;
    logic              s2_sticky;
    logic signed [E_W-1:0] s2_exp;

    // ---------------- S3: round, pack ----------------
    logic              inc;
    logic              carry;
    logic [FRAC_W-1:0] frac_r;
    logic signed [E_W-1:0] e3_n;
    logic [W-1:0]      c_n;
    logic              of_n, uf_n, inv_n;

    assign inc = s2_guard && (s2_sticky || s2_frac[0]);
    // A fraction carry-out means the significand rolled over to 1.0; frac_r is then zero
    assign {carry, frac_r} = (FRAC_W + 1)'(s2_frac) + (FRAC_W + 1)'(inc);
    assign e3_n = s2_exp + E_W'(carry);

    always_comb begin
        c_n   = '0;
        of_n  = 1'b0;
        uf_n  = 1'b0;
        inv_n = 1'b0;
        if (s2_sp.nan) begin
            c_n   = QNAN;
            inv_n = 1'b1;
        end else if (s2_sp.inf) begin
            c_n = {s2_sp.sign, INF_MAG};
        end else if (s2_sp.zero) begin
            c_n = {s2_sp.sign, {(W-1){1'b0}}};
        end else if (e3_n >= E_TOP) begin
            c_n  = {s2_sp.sign, INF_MAG};
            of_n = 1'b1;
        end else if (e3_n < E_ONE) begin
            c_n  = {s2_sp.sign, {(W-1){1'b0}}};
            uf_n = 1'b1;
        end else begin
            c_n = {s2_sp.sign, e3_n[EXP_W-1:0], frac_r};
        end
    end

    logic         s3_vld;
    logic [W-1:0] s3_c;
    logic         s3_of, s3_uf, s3_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_sp     <= '0;
            s1_prod   <= '0;
            s1_esum   <= '0;
            s2_vld    <= 1'b0;
            s2_sp     <= '0;
            s2_frac   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_exp    <= '0;
            s3_vld    <= 1'b0;
            s3_c      <= '0;
            s3_of     <= 1'b0;
            s3_uf     <= 1'b0;
            s3_inv    <= 1'b0;
        end else if (adv) begin
            s1_vld    <= bus.in_valid;
            s1_sp     <= sp_n;
            s1_prod   <= prod_n;
            s1_esum   <= esum_n;
            s2_vld    <= s1_vld;
            s2_sp     <= s1_sp;
            s2_frac   <= norm[PROD_W-1 -: FRAC_W];
            s2_guard  <= norm[FRAC_W+1];
            s2_sticky <= |norm[FRAC_W:0];
            s2_exp    <= e2_n;
            s3_vld    <= s2_vld;
            s3_c      <= c_n;
            s3_of     <= of_n;
            s3_uf     <= uf_n;
            s3_inv    <= inv_n;
        end
    end

    assign bus.out_valid = s3_vld;
    assign bus.c         = s3_c;
    assign bus.of        = s3_of;
    assign bus.uf        = s3_uf;
    assign bus.inv       = s3_inv;

endmodule

// File: tb/tb_float_multiplier_pipe.sv
// fp16 bench: exact-integer reference model plus scoreboard, directed and random streams.
module tb_float_multiplier_pipe;

    localparam int EW   = 5;
    localparam int FW   = 10;
    localparam int W    = 16;
    localparam int BIAS = 15;
    localparam int EMAX = 31;

    typedef struct packed {
        logic [W-1:0] c;
        logic         of;
        logic         uf;
        logic         inv;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_multiplier_pipe_if #(.W(W)) bus ();

    float_multiplier_pipe #(.EXP_W(EW), .FRAC_W(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    bit   check_lat = 1'b0;
    exp_t exp_q[$];
    res_t prev;
    bit   prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Value = m * 2^k per operand; exact product, then RNE on the integer remainder
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t   r;
        logic   s;
        int     ex, ey, fx, fy, kx, ky, k, p, e, sh;
        longint mx, my, m, q, rem, half;
        bit     nx, ny, ix, iy, zx, zy;
        r  = '0;
        s  = x[W-1] ^ y[W-1];
        ex = int'(x[W-2:FW]);
        ey = int'(y[W-2:FW]);
        fx = int'(x[FW-1:0]);
        fy = int'(y[FW-1:0]);
        nx = (ex == EMAX) && (fx != 0);
        ny = (ey == EMAX) && (fy != 0);
        ix = (ex == EMAX) && (fx == 0);
        iy = (ey == EMAX) && (fy == 0);
        zx = (ex == 0) && (fx == 0);
        zy = (ey == 0) && (fy == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            r.c   = {1'b0, 5'h1F, 1'b1, 9'h000};
            r.inv = 1'b1;
        end else if (ix || iy) begin
            r.c = {s, 5'h1F, 10'h000};
        end else if (zx || zy) begin
            r.c = {s, 15'h0000};
        end else begin
            mx = (ex == 0) ? longint'(fx) : longint'(fx) + (longint'(1) << FW);
            my = (ey == 0) ? longint'(fy) : longint'(fy) + (longint'(1) << FW);
            kx = ((ex == 0) ? 1 : ex) - BIAS - FW;
            ky = ((ey == 0) ? 1 : ey) - BIAS - FW;
            m  = mx * my;
            k  = kx + ky;
            p  = 0;
            while (p < 62 && (m >> (p + 1)) != 0) p++;
            e  = p + k + BIAS;
            sh = p - FW;
            if (sh > 0) begin
                q    = m >> sh;
                rem  = m - (q << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && (q % 2) == 1)) q++;
                if (q == (longint'(1) << (FW + 1))) begin
                    q = q >> 1;
                    e++;
                end
            end else begin
                q = m << (-sh);
            end
            if (e >= EMAX) begin
                r.c  = {s, 5'h1F, 10'h000};
                r.of = 1'b1;
            end else if (e <= 0) begin
                r.c  = {s, 15'h0000};
                r.uf = 1'b1;
            end else begin
                r.c = {s, 5'(e), 10'(q)};
            end
        end
        return r;
    endfunction

    task automatic pin(input logic [W-1:0] x, input logic [W-1:0] y, input res_t want);
        check($sformatf("model_%h_x_%h", x, y), 32'(model(x, y)), 32'(want));
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [4:0] e;
        logic [9:0] f;
        case ($urandom_range(0, 7))
            0:       e = 5'd0;
            1:       e = 5'd31;
            2:       e = 5'($urandom_range(1, 6));
            3:       e = 5'($urandom_range(24, 30));
            default: e = 5'($urandom_range(8, 22));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
        return {1'($urandom), e, f};
    endfunction

    task automatic drive(input bit v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input bit ordy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = xa;
        bus.b         = xb;
        bus.out_ready = ordy;
    endtask

    // Scoreboard: settled mid-cycle view of what the next rising edge will transfer
    always @(negedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (prev_stall) begin
                check("stall_valid_held", 32'(bus.out_valid), 32'd1);
                check("stall_result_held", 32'({bus.c, bus.of, bus.uf, bus.inv}), 32'(prev));
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got c=%h with no beat outstanding (t=%0t)",
                             bus.c, $time);
                end else begin
                    check("result", 32'({bus.c, bus.of, bus.uf, bus.inv}), 32'(exp_q[0].r));
                    if (bus.out_ready) begin
                        if (check_lat) check("latency", 32'(cyc - exp_q[0].acc), 32'd3);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = {bus.c, bus.of, bus.uf, bus.inv};
            if (bus.in_valid && bus.in_ready) exp_q.push_back('{model(bus.a, bus.b), cyc});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] dir_a [11] = '{16'h3C00, 16'h3E00, 16'h3C01, 16'hC000, 16'h7BFF, 16'h7C00,
                                 16'h7C00, 16'h0200, 16'h0400, 16'h3E00, 16'h3E00};
    logic [W-1:0] dir_b [11] = '{16'h4000, 16'h3E00, 16'h3C01, 16'h3800, 16'h4000, 16'h0000,
                                 16'hC000, 16'h4800, 16'h3800, 16'h3C01, 16'h3C03};
    logic [W-1:0] bp_a  [5]  = '{16'h3C00, 16'h4200, 16'hB555, 16'h0123, 16'h4BCD};
    logic [W-1:0] bp_b  [5]  = '{16'h4400, 16'h3A00, 16'h3C07, 16'h5800, 16'hC321};

    initial begin
        int sent;
        int idx;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Hand-computed values pin the reference model
        pin(16'h3C00, 16'h4000, {16'h4000, 3'b000});
        pin(16'h3E00, 16'h3E00, {16'h4080, 3'b000});
        pin(16'h3C01, 16'h3C01, {16'h3C02, 3'b000});
        pin(16'hC000, 16'h3800, {16'hBC00, 3'b000});
        pin(16'h7BFF, 16'h4000, {16'h7C00, 3'b100});
        pin(16'h7C00, 16'h0000, {16'h7E00, 3'b001});
        pin(16'h7C00, 16'hC000, {16'hFC00, 3'b000});
        pin(16'h0200, 16'h4800, {16'h0C00, 3'b000});
        pin(16'h0400, 16'h3800, {16'h0000, 3'b010});
        pin(16'h3E00, 16'h3C01, {16'h3E02, 3'b000});
        pin(16'h3E00, 16'h3C03, {16'h3E04, 3'b000});

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_c", 32'(bus.c), 32'd0);
        check("reset_flags", 32'({bus.of, bus.uf, bus.inv}), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;

        // Directed back-to-back vectors at full rate, latency checked
        check_lat = 1'b1;
        for (int i = 0; i < 11; i++) drive(1'b1, dir_a[i], dir_b[i], 1'b1);
        repeat (5) drive(1'b0, '0, '0, 1'b1);
        check_lat = 1'b0;
        check("directed_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: 5 beats, consumer stalls for 4 cycles mid-stream
        sent = 0;
        for (int t = 0; t < 20; t++) begin
            idx = (sent < 5) ? sent : 4;
            drive(sent < 5, bp_a[idx], bp_b[idx], !(t >= 3 && t < 7));
            #1;
            if (t == 4 || t == 5) check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check("bp_all_sent", 32'(sent), 32'd5);
        #3;
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight and the head beat unconsumed
        for (int i = 0; i < 3; i++) drive(1'b1, bp_a[i], bp_b[i], 1'b1);
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_flush_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (6) drive(1'b0, '0, '0, 1'b1);
        check_lat = 1'b1;
        drive(1'b1, 16'h3C00, 16'h4000, 1'b1);
        repeat (5) drive(1'b0, '0, '0, 1'b1);
        check_lat = 1'b0;
        #3;
        check("post_reset_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic with random consumer stalls
        for (int t = 0; t < 2000; t++)
            drive($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), $urandom_range(0, 9) < 7);
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            drive(1'b0, '0, '0, 1'b1);
            #3;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
